// File: rtl/maxpool_pkg.sv
// Shared types and the fp32 ordering helper for the 2x2 max-pooling controller.
package maxpool_pkg;

   typedef struct packed {
      logic       sgn;
      logic [7:0] exp;
      logic [22:0] mant;
   } fp32_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // True when a is strictly greater than b. Ordering is purely on bit fields:
   // a positive value beats a negative one (so +0 beats -0), positives order by
   // magnitude, negatives by reversed magnitude. NaN/Inf get no special case.
   function automatic logic fp32_gt(input fp32_t a, input fp32_t b);
      logic gt;
      if (a.sgn != b.sgn) begin
         gt = b.sgn;
      end else if (!a.sgn) begin
         gt = ({a.exp, a.mant} > {b.exp, b.mant});
      end else begin
         gt = ({a.exp, a.mant} < {b.exp, b.mant});
      end
      return gt;
   endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational fp32 maximum of two operands; ties resolve to a.
module fp32_max2
   import maxpool_pkg::*;
(
   input  fp32_t a,
   input  fp32_t b,
   output fp32_t y,
   output logic  sel_b
);

   // pick b only when it is strictly greater, so a wins on equality
   always_comb begin
      sel_b = fp32_gt(b, a);
      y     = sel_b ? b : a;
   end

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// Streaming 2x2 stride-2 max-pool controller for fp32 row-major pixel streams.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid may not depend on ready, and a presented output holds its
// data stable until it is taken.
module maxpool2x2_ctrl
   import maxpool_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output state_t      o_dbg_state
);

   localparam int CW  = $clog2(WIDTH);
   localparam int RW  = $clog2(HEIGHT);
   localparam int LBW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   localparam int LBN = WIDTH / 2;

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   fp32_t         r_hold;
   fp32_t         r_linebuf [LBN];
   logic [31:0]   r_out_data;
   logic          r_out_valid;
   logic          r_out_last;

   logic          w_accept;
   logic          w_out_hs;
   logic          w_col_last;
   logic          w_row_last;
   logic          w_last_pix;
   logic          w_emit;
   logic [LBW-1:0] w_lb_idx;
   fp32_t         w_pix;
   fp32_t         w_h;
   fp32_t         w_v;
   logic          w_h_sel_b;
   logic          w_v_sel_b;

   assign w_pix      = fp32_t'(in_data);
   assign w_lb_idx   = LBW'(r_col >> 1);
   assign in_ready   = (r_state == RUN) && !(r_out_valid && !out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_out_hs   = r_out_valid && out_ready;
   assign w_col_last = (r_col == CW'(WIDTH - 1));
   assign w_row_last = (r_row == RW'(HEIGHT - 1));
   assign w_last_pix = w_accept && w_col_last && w_row_last;
   assign w_emit     = w_accept && r_col[0] && r_row[0];

   assign busy        = (r_state != IDLE);
   assign done        = w_out_hs && r_out_last;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_last    = r_out_last;
   assign o_dbg_state = r_state;

   // horizontal pair: held even-column pixel against the odd-column pixel
   fp32_max2 u_max_h (
      .a     (r_hold),
      .b     (w_pix),
      .y     (w_h),
      .sel_b (w_h_sel_b)
   );

   // vertical pair: stored upper-row maximum against the current horizontal one
   fp32_max2 u_max_v (
      .a     (r_linebuf[w_lb_idx]),
      .b     (w_h),
      .y     (w_v),
      .sel_b (w_v_sel_b)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // next-state logic: start only matters in IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start)      w_next_state = RUN;
         RUN:     if (w_last_pix) w_next_state = FLUSH;
         FLUSH:   if (done)       w_next_state = IDLE;
         default:                 w_next_state = IDLE;
      endcase
   end

   // column/row position of the next pixel, cleared on an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // even-column pixel waits here for its horizontal partner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_hold <= '0;
      else if (w_accept && !r_col[0]) r_hold <= w_pix;
   end

   // half-row of pair maxima; every entry is written on the even row before
   // the odd row reads it, so no clearing is needed
   always_ff @(posedge clk) begin
      if (w_accept && r_col[0] && !r_row[0]) r_linebuf[w_lb_idx] <= w_h;
   end

   // output register: a new window result wins over a drain in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_emit) begin
         r_out_data  <= w_v;
         r_out_valid <= 1'b1;
         r_out_last  <= w_last_pix;
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Bench for maxpool2x2_ctrl on a 4x4 frame: ramp, negatives/zeros/ties,
// back-pressure, start while busy, reset mid-frame and random frames.
module tb_maxpool2x2_ctrl;
   import maxpool_pkg::*;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        busy, done, in_ready, out_valid, out_last;
   logic [31:0] out_data;
   state_t      dbg_state;

   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   logic [32:0] exp_q [$];
   logic [32:0] exp_e;

   logic [31:0] ramp_px [NPIX];
   logic [31:0] mix_px  [NPIX];
   logic [31:0] rnd_px  [NPIX];

   maxpool2x2_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .o_dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // small non-negative integer to fp32 bits
   function automatic logic [31:0] i2f(input int v);
      int e;
      if (v == 0) return 32'h0;
      e = 0;
      while ((v >> (e + 1)) != 0) e++;
      return {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
   endfunction

   // map fp32 bits to an unsigned key whose integer order is the max order
   function automatic logic [31:0] ord_key(input logic [31:0] x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction

   function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
      return (ord_key(b) > ord_key(a)) ? b : a;
   endfunction

   // scoreboard: compare every output handshake against the expected queue
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            chk("out_data", out_data, exp_e[31:0]);
            chk("out_last", 32'(out_last), 32'(exp_e[32]));
            chk("done_with_last", 32'(done), 32'(exp_e[32]));
         end
      end else if (done) begin
         chk("spurious_done", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
   end

   task automatic drive_pixel(input logic [31:0] d, input bit st);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      start    = st;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] px [NPIX], input int start_idx, input int max_gap);
      int d0;
      int n;
      logic [31:0] top_m, bot_m;
      d0 = done_cnt;
      for (int r = 0; r < H; r += 2) begin
         for (int c = 0; c < W; c += 2) begin
            top_m = ref_max(px[r*W + c], px[r*W + c + 1]);
            bot_m = ref_max(px[(r+1)*W + c], px[(r+1)*W + c + 1]);
            exp_q.push_back({(r == H-2) && (c == W-2), ref_max(top_m, bot_m)});
         end
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < NPIX; i++) begin
         repeat ($urandom_range(0, max_gap)) @(posedge clk);
         #0;
         drive_pixel(px[i], i == start_idx);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("state_idle", 32'(dbg_state), 32'(IDLE));
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_busy"},      32'(busy),      32'd0);
      chk({pfx, "_done"},      32'(done),      32'd0);
      chk({pfx, "_in_ready"},  32'(in_ready),  32'd0);
      chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({pfx, "_out_last"},  32'(out_last),  32'd0);
      chk({pfx, "_out_data"},  out_data,       32'd0);
   endtask

   // overall time limit
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NPIX; i++) ramp_px[i] = i2f(i);
      for (int i = 0; i < NPIX; i++) mix_px[i] = $urandom;
      // window (0,0): -3, -1 / -2, -8
      mix_px[0]  = 32'hC040_0000; mix_px[1]  = 32'hBF80_0000;
      mix_px[4]  = 32'hC000_0000; mix_px[5]  = 32'hC100_0000;
      // window (0,1): signed zeros
      mix_px[2]  = 32'h8000_0000; mix_px[3]  = 32'h0000_0000;
      mix_px[6]  = 32'h8000_0000; mix_px[7]  = 32'h8000_0000;
      // window (1,0): all 2.0
      mix_px[8]  = 32'h4000_0000; mix_px[9]  = 32'h4000_0000;
      mix_px[12] = 32'h4000_0000; mix_px[13] = 32'h4000_0000;

      // reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // ramp; first and last expected values pinned as constants too
      chk("ramp_first_model", ref_max(ref_max(ramp_px[0], ramp_px[1]), ref_max(ramp_px[4], ramp_px[5])), 32'h40A0_0000);
      run_frame(ramp_px, -1, 0);

      // negatives, signed zeros, ties, random window
      run_frame(mix_px, -1, 0);

      // back-pressure on the first output
      fork
         run_frame(ramp_px, -1, 0);
         begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
               @(posedge clk); #1;
               n++;
            end
            chk("bp_valid_seen", 32'(out_valid), 32'd1);
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_hold_data", out_data, 32'h40A0_0000);
               chk("bp_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join

      // start pulsed mid-frame is ignored
      run_frame(ramp_px, 7, 0);

      // reset after six pixels: first window result is pending at that point
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) drive_pixel(ramp_px[i], 1'b0);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_data", out_data, 32'h40A0_0000);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      run_frame(ramp_px, -1, 0);

      // random data, random input gaps and random downstream stalls
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NPIX; i++) rnd_px[i] = $urandom;
         fork
            run_frame(rnd_px, -1, 2);
            begin
               repeat (60) begin
                  @(posedge clk); #1;
                  out_ready = 1'($urandom_range(0, 1));
               end
               out_ready = 1'b1;
            end
         join
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
